// File: rtl/fsab_slave_buffer_pkg.sv
// Shared FSAB field widths, opcodes and types for the slave buffer.
package fsab_slave_buffer_pkg;

  localparam int FSAB_REQ_HI          = 0;
  localparam logic [FSAB_REQ_HI:0] FSAB_REQ_RD = 1'b0;
  localparam logic [FSAB_REQ_HI:0] FSAB_REQ_WR = 1'b1;
  localparam int FSAB_DID_HI          = 3;
  localparam int FSAB_ADDR_HI         = 31;
  localparam int FSAB_LEN_HI          = 3;
  localparam int FSAB_DATA_HI         = 31;
  localparam int FSAB_MASK_HI         = 3;
  localparam int FSAB_INITIAL_CREDITS = 4;

  localparam int LEN_W = FSAB_LEN_HI + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WBEATS = 2'd1,
    ST_WDROP  = 2'd2
  } cap_state_t;

  typedef struct packed {
    logic [FSAB_REQ_HI:0]  mode;
    logic [FSAB_DID_HI:0]  did;
    logic [FSAB_DID_HI:0]  subdid;
    logic [FSAB_ADDR_HI:0] addr;
    logic [FSAB_LEN_HI:0]  len;
  } fsab_cmd_t;

  localparam int CMD_W = $bits(fsab_cmd_t);
  localparam int WD_W  = (FSAB_DATA_HI + 1) + (FSAB_MASK_HI + 1);

  // Beats actually captured for a request: zero counts as one, long
  // requests are clipped to the buffer's per-transaction limit.
  function automatic logic [FSAB_LEN_HI:0] fsab_eff_len(
    input logic [FSAB_LEN_HI:0] len,
    input logic [FSAB_LEN_HI:0] max_len
  );
    if (len == '0)          return LEN_W'(1);
    else if (len > max_len) return max_len;
    else                    return len;
  endfunction

endpackage

// File: rtl/fsab_slave_buffer_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy counter.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module fsab_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty_b,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_pop_ok;
  logic w_push_ok;

  assign empty_b   = (r_count != '0);
  assign full      = (r_count == CNT_W'(DEPTH));
  assign w_pop_ok  = pop & empty_b;
  assign w_push_ok = push & (~full | w_pop_ok);
  assign dout      = r_mem[r_rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap at DEPTH; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fsab_slave_buffer.sv
// FSAB slave buffer: captures arbiter requests into command and write-data
// FIFOs, presents them to the memory controller and returns one credit per
// dequeued command.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for a header beat
// ST_WBEATS | capturing the remaining write beats of the current request
// ST_WDROP  | discarding write beats beyond MAX_LEN of an oversize request
module fsab_slave_buffer
  import fsab_slave_buffer_pkg::*;
#(
  parameter int CMD_DEPTH  = FSAB_INITIAL_CREDITS,
  parameter int MAX_LEN    = 8,
  parameter int DATA_DEPTH = CMD_DEPTH * MAX_LEN
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  fsabo_valid,
  input  logic [FSAB_REQ_HI:0]  fsabo_mode,
  input  logic [FSAB_DID_HI:0]  fsabo_did,
  input  logic [FSAB_DID_HI:0]  fsabo_subdid,
  input  logic [FSAB_ADDR_HI:0] fsabo_addr,
  input  logic [FSAB_LEN_HI:0]  fsabo_len,
  input  logic [FSAB_DATA_HI:0] fsabo_data,
  input  logic [FSAB_MASK_HI:0] fsabo_mask,
  output logic                  fsabo_credit,
  output logic                  cmd_valid,
  output logic [FSAB_REQ_HI:0]  cmd_mode,
  output logic [FSAB_DID_HI:0]  cmd_did,
  output logic [FSAB_DID_HI:0]  cmd_subdid,
  output logic [FSAB_ADDR_HI:0] cmd_addr,
  output logic [FSAB_LEN_HI:0]  cmd_len,
  input  logic                  cmd_ready,
  output logic                  wd_valid,
  output logic [FSAB_DATA_HI:0] wd_data,
  output logic [FSAB_MASK_HI:0] wd_mask,
  input  logic                  wd_ready,
  output logic                  overflow
);

  localparam logic [FSAB_LEN_HI:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  cap_state_t           r_state, w_state_nxt;
  logic [FSAB_LEN_HI:0] r_remain, w_remain_nxt;
  logic [FSAB_LEN_HI:0] r_drop, w_drop_nxt;
  logic                 r_credit;
  logic                 r_overflow;

  logic [FSAB_LEN_HI:0] w_len_eff;
  logic [FSAB_LEN_HI:0] w_len_extra;
  logic                 w_len_bad;
  logic                 w_cmd_push, w_wd_push;
  logic                 w_cmd_pop, w_wd_pop;
  logic                 w_cmd_full, w_wd_full;
  logic                 w_cmd_empty_b, w_wd_empty_b;
  fsab_cmd_t            w_cmd_in, w_cmd_head;
  logic [CMD_W-1:0]     w_cmd_dout;
  logic [WD_W-1:0]      w_wd_dout;

  // The stored length is the number of beats actually captured, so the
  // controller can always pop cmd_len beats per write without stalling.
  assign w_len_eff   = fsab_eff_len(fsabo_len, MAX_LEN_L);
  assign w_len_extra = (fsabo_len > w_len_eff) ? fsabo_len - w_len_eff : '0;
  assign w_cmd_in    = '{mode: fsabo_mode, did: fsabo_did, subdid: fsabo_subdid,
                         addr: fsabo_addr, len: w_len_eff};

  // Capture FSM: header in IDLE, remaining write beats in WBEATS, excess
  // beats of an oversize write swallowed in WDROP.
  always_comb begin
    w_state_nxt  = r_state;
    w_remain_nxt = r_remain;
    w_drop_nxt   = r_drop;
    w_cmd_push   = 1'b0;
    w_wd_push    = 1'b0;
    w_len_bad    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (fsabo_valid) begin
          w_cmd_push = 1'b1;
          w_len_bad  = (fsabo_len == '0) || (fsabo_len > MAX_LEN_L);
          if (fsabo_mode == FSAB_REQ_WR) begin
            w_wd_push  = 1'b1;
            w_drop_nxt = w_len_extra;
            if (w_len_eff > LEN_W'(1)) begin
              w_remain_nxt = w_len_eff - LEN_W'(1);
              w_state_nxt  = ST_WBEATS;
            end else if (w_len_extra != '0) begin
              w_state_nxt = ST_WDROP;
            end
          end
        end
      end
      ST_WBEATS: begin
        if (fsabo_valid) begin
          w_wd_push    = 1'b1;
          w_remain_nxt = r_remain - LEN_W'(1);
          if (r_remain == LEN_W'(1))
            w_state_nxt = (r_drop != '0) ? ST_WDROP : ST_IDLE;
        end
      end
      ST_WDROP: begin
        if (fsabo_valid) begin
          w_drop_nxt = r_drop - LEN_W'(1);
          if (r_drop == LEN_W'(1)) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM and beat counter registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state  <= ST_IDLE;
      r_remain <= '0;
      r_drop   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_remain <= w_remain_nxt;
      r_drop   <= w_drop_nxt;
    end
  end

  assign w_cmd_pop = w_cmd_empty_b & cmd_ready;
  assign w_wd_pop  = w_wd_empty_b & wd_ready;

  // Credit follows each command dequeue by one cycle; overflow is sticky.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_credit   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_credit   <= w_cmd_pop;
      r_overflow <= r_overflow | w_len_bad
                  | (w_cmd_push & w_cmd_full & ~w_cmd_pop)
                  | (w_wd_push & w_wd_full & ~w_wd_pop);
    end
  end

  fsab_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst_b   (rst_b),
    .push    (w_cmd_push),
    .pop     (cmd_ready),
    .din     (w_cmd_in),
    .dout    (w_cmd_dout),
    .empty_b (w_cmd_empty_b),
    .full    (w_cmd_full)
  );

  fsab_sync_fifo #(.WIDTH(WD_W), .DEPTH(DATA_DEPTH)) u_wd_fifo (
    .clk     (clk),
    .rst_b   (rst_b),
    .push    (w_wd_push),
    .pop     (wd_ready),
    .din     ({fsabo_data, fsabo_mask}),
    .dout    (w_wd_dout),
    .empty_b (w_wd_empty_b),
    .full    (w_wd_full)
  );

  assign w_cmd_head   = w_cmd_dout;
  assign cmd_valid    = w_cmd_empty_b;
  assign cmd_mode     = w_cmd_head.mode;
  assign cmd_did      = w_cmd_head.did;
  assign cmd_subdid   = w_cmd_head.subdid;
  assign cmd_addr     = w_cmd_head.addr;
  assign cmd_len      = w_cmd_head.len;
  assign wd_valid     = w_wd_empty_b;
  assign wd_data      = w_wd_dout[WD_W-1 -: FSAB_DATA_HI+1];
  assign wd_mask      = w_wd_dout[FSAB_MASK_HI:0];
  assign fsabo_credit = r_credit;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_fsab_slave_buffer.sv
// Scoreboard bench for fsab_slave_buffer: stimulus pushes expected commands
// and beats into queues, a negedge monitor pops and compares on handshakes.
module tb_fsab_slave_buffer;
  import fsab_slave_buffer_pkg::*;

  localparam int CMD_DEPTH  = 4;
  localparam int MAX_LEN    = 8;
  localparam int DATA_DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        fsabo_valid = 1'b0;
  logic [0:0]  fsabo_mode = '0;
  logic [3:0]  fsabo_did = '0, fsabo_subdid = '0, fsabo_len = '0, fsabo_mask = '0;
  logic [31:0] fsabo_addr = '0, fsabo_data = '0;
  logic        fsabo_credit, cmd_valid, wd_valid, overflow;
  logic [0:0]  cmd_mode;
  logic [3:0]  cmd_did, cmd_subdid, cmd_len, wd_mask;
  logic [31:0] cmd_addr, wd_data;
  logic        cmd_ready = 1'b0, wd_ready = 1'b0;

  fsab_slave_buffer #(.CMD_DEPTH(CMD_DEPTH), .MAX_LEN(MAX_LEN), .DATA_DEPTH(DATA_DEPTH)) dut (
    .clk(clk), .rst_b(rst_b), .fsabo_valid(fsabo_valid), .fsabo_mode(fsabo_mode),
    .fsabo_did(fsabo_did), .fsabo_subdid(fsabo_subdid), .fsabo_addr(fsabo_addr),
    .fsabo_len(fsabo_len), .fsabo_data(fsabo_data), .fsabo_mask(fsabo_mask),
    .fsabo_credit(fsabo_credit), .cmd_valid(cmd_valid), .cmd_mode(cmd_mode),
    .cmd_did(cmd_did), .cmd_subdid(cmd_subdid), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_ready(cmd_ready), .wd_valid(wd_valid), .wd_data(wd_data), .wd_mask(wd_mask),
    .wd_ready(wd_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [3:0]  did, sub;
    logic [31:0] addr;
    logic [3:0]  len;
    int          cyc;
  } ecmd_t;
  typedef struct {
    logic [31:0] data;
    logic [3:0]  mask;
    int          cyc;
  } ebeat_t;

  ecmd_t  cq[$];
  ebeat_t dq[$];
  int     cyc = 0;
  bit     exp_ovf = 0;
  bit     rand_rdy = 0, cmd_rdy_fix = 1, wd_rdy_fix = 1;
  bit     prev_hs = 0, cev, dev;
  int     n_chk = 0, n_pass = 0, n_credit = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // One clock of stimulus; decides from queue occupancy whether a push is lost.
  task automatic tick(input bit pc, input bit pd, input logic [3:0] elen);
    bit cpop, dpop;
    cmd_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : cmd_rdy_fix;
    wd_ready  = rand_rdy ? ($urandom_range(0, 1) == 1) : wd_rdy_fix;
    cpop = cmd_ready && (cq.size() > 0);
    dpop = wd_ready && (dq.size() > 0);
    if (pc) begin
      if (cq.size() == CMD_DEPTH && !cpop) exp_ovf = 1;
      else cq.push_back('{fsabo_mode, fsabo_did, fsabo_subdid, fsabo_addr, elen, cyc + 1});
    end
    if (pd) begin
      if (dq.size() == DATA_DEPTH && !dpop) exp_ovf = 1;
      else dq.push_back('{fsabo_data, fsabo_mask, cyc + 1});
    end
    @(posedge clk); #1;
    fsabo_valid = 1'b0;
  endtask

  // One whole request; header fields on later beats are scrambled on purpose.
  task automatic send(input bit wr, input logic [3:0] did, input logic [3:0] sub,
                      input logic [31:0] addr, input logic [3:0] len,
                      input logic [31:0] dbase, input int gap_at, input int gap_n);
    int nb, e;
    nb = wr ? ((len == 0) ? 1 : int'(len)) : 1;
    e  = (len == 0) ? 1 : ((int'(len) > MAX_LEN) ? MAX_LEN : int'(len));
    if (len == 0 || int'(len) > MAX_LEN) exp_ovf = 1;
    for (int i = 0; i < nb; i++) begin
      fsabo_valid = 1'b1;
      if (i == 0) begin
        fsabo_mode = wr; fsabo_did = did; fsabo_subdid = sub;
        fsabo_addr = addr; fsabo_len = len;
      end else begin
        fsabo_mode = 1'($urandom); fsabo_did = 4'($urandom); fsabo_subdid = 4'($urandom);
        fsabo_addr = $urandom; fsabo_len = 4'($urandom);
      end
      fsabo_data = dbase + 32'(i);
      fsabo_mask = 4'($urandom);
      tick(i == 0, wr && (i < e), 4'(e));
      if (i == gap_at) repeat (gap_n) tick(0, 0, '0);
    end
  endtask

  task automatic drain();
    rand_rdy = 0; cmd_rdy_fix = 1; wd_rdy_fix = 1;
    for (int i = 0; i < 200 && (cq.size() > 0 || dq.size() > 0); i++) tick(0, 0, '0);
    chk("drain_cmd_left", cq.size(), 0);
    chk("drain_wd_left", dq.size(), 0);
    repeat (2) tick(0, 0, '0);
  endtask

  task automatic do_reset();
    fsabo_valid = 1'b0;
    rst_b = 1'b0;
    cq.delete(); dq.delete();
    exp_ovf = 0;
    #1;
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_wd_valid", wd_valid, 0);
    chk("rst_credit", fsabo_credit, 0);
    chk("rst_overflow", overflow, 0);
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
  endtask

  // Monitor: checks visibility, credit timing and head contents on handshakes.
  always @(negedge clk) begin
    if (!rst_b) begin
      prev_hs = 0;
    end else begin
      cev = (cq.size() > 0) && (cq[0].cyc <= cyc);
      dev = (dq.size() > 0) && (dq[0].cyc <= cyc);
      chk("cmd_valid", cmd_valid, cev);
      chk("wd_valid", wd_valid, dev);
      chk("credit", fsabo_credit, prev_hs);
      if (fsabo_credit) n_credit++;
      prev_hs = 0;
      if (cev && cmd_ready) begin
        chk("cmd_mode", cmd_mode, cq[0].mode);
        chk("cmd_did", cmd_did, cq[0].did);
        chk("cmd_subdid", cmd_subdid, cq[0].sub);
        chk("cmd_addr", cmd_addr, cq[0].addr);
        chk("cmd_len", cmd_len, cq[0].len);
        void'(cq.pop_front());
        prev_hs = 1;
      end
      if (dev && wd_ready) begin
        chk("wd_data", wd_data, dq[0].data);
        chk("wd_mask", wd_mask, dq[0].mask);
        void'(dq.pop_front());
      end
    end
  end

  initial begin
    #2;
    do_reset();
    tick(0, 0, '0);

    // Single read with ready held high.
    n_credit = 0;
    send(0, 4'd2, 4'd1, 32'h100, 4'd8, 0, -1, 0);
    drain();
    chk("t1_credit_count", n_credit, 1);

    // Single write, 2-cycle gap after beat 1.
    send(1, 4'd3, 4'd0, 32'h200, 4'd4, 32'hA0, 1, 2);
    drain();
    chk("t2_overflow", overflow, exp_ovf);

    // Full command FIFO, fifth header with pop held off.
    cmd_rdy_fix = 0;
    for (int i = 0; i < 4; i++) send(0, 4'(i), 4'd0, 32'h300 + 32'(i), 4'd1, 0, -1, 0);
    chk("t3_ovf_before", overflow, exp_ovf);
    send(0, 4'd9, 4'd9, 32'h3FF, 4'd1, 0, -1, 0);
    chk("t3_ovf_after", overflow, exp_ovf);
    chk("t3_ovf_expect", exp_ovf, 1);
    drain();

    // Variant: fifth header arrives with a pop in the same cycle.
    do_reset();
    cmd_rdy_fix = 0;
    for (int i = 0; i < 4; i++) send(0, 4'(i), 4'd1, 32'h400 + 32'(i), 4'd2, 0, -1, 0);
    cmd_rdy_fix = 1;
    send(0, 4'd5, 4'd5, 32'h4FF, 4'd2, 0, -1, 0);
    chk("t3v_overflow", overflow, exp_ovf);

    // Back-to-back credits from four queued commands.
    drain();
    cmd_rdy_fix = 0;
    for (int i = 0; i < 4; i++) send(0, 4'(i), 4'd2, 32'h500 + 32'(i), 4'd3, 0, -1, 0);
    n_credit = 0;
    drain();
    chk("t4_credit_count", n_credit, 4);

    // Illegal lengths, then a read to prove the FSM is back in IDLE.
    send(1, 4'd6, 4'd0, 32'h600, 4'd0, 32'hB0, -1, 0);
    send(1, 4'd7, 4'd0, 32'h700, 4'd10, 32'hC0, 3, 1);
    send(0, 4'd8, 4'd0, 32'h800, 4'd1, 0, -1, 0);
    drain();
    chk("t5_overflow", overflow, exp_ovf);

    // Reset in the middle of a write burst.
    do_reset();
    cmd_rdy_fix = 0;
    send(0, 4'd1, 4'd1, 32'h900, 4'd1, 0, -1, 0);
    fsabo_valid = 1; fsabo_mode = 1; fsabo_did = 2; fsabo_subdid = 0;
    fsabo_addr = 32'hA00; fsabo_len = 4; fsabo_data = 32'hD0; fsabo_mask = 4'hF;
    tick(1, 1, 4'd4);
    fsabo_valid = 1; fsabo_data = 32'hD1;
    tick(0, 1, '0);
    do_reset();
    send(0, 4'd4, 4'd3, 32'hB00, 4'd2, 32'hEE, -1, 0);
    drain();
    chk("t6_overflow", overflow, exp_ovf);

    // Randomised traffic with random controller back-pressure.
    do_reset();
    rand_rdy = 1;
    for (int t = 0; t < 40; t++) begin
      send($urandom_range(0, 1) == 1, 4'($urandom), 4'($urandom), $urandom,
           4'($urandom_range(1, MAX_LEN)), $urandom, int'($urandom_range(0, 7)),
           int'($urandom_range(0, 2)));
      rand_rdy = 1;
    end
    drain();
    chk("rand_overflow", overflow, exp_ovf);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
